// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and helpers for the load/store unit.
// Imported by load_store_unit and load_extend.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   function automatic logic [2:0] beat_count(input logic [2:0] f3);
      logic [2:0] n;
      n = 3'd1;
      if (f3 == F3_H || f3 == F3_HU)
         n = 3'd2;
      else if (f3 == F3_W)
         n = 3'd4;
      return n;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Size and sign extension of the assembled load bytes.
// Purely combinational.
module load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] data,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata
);

   // Select width and extension from the size code
   always_comb begin
      rdata = '0;
      unique case (1'b1)
         (funct3 == F3_B):  rdata = {{24{data[7]}}, data[7:0]};
         (funct3 == F3_BU): rdata = {24'h0, data[7:0]};
         (funct3 == F3_H):  rdata = {{16{data[15]}}, data[15:0]};
         (funct3 == F3_HU): rdata = {16'h0, data[15:0]};
         (funct3 == F3_W):  rdata = data;
         default:           rdata = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit between the pipeline and an 8-bit memory.
// Halfwords and words are moved one little-endian byte per beat.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready
);

   state_t      state;
   logic        up_q;
   logic        we_q;
   logic        err_q;
   logic [2:0]  f3_q;
   logic [2:0]  beat_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] data_q;
   logic [31:0] ext;
   logic        illegal;
   logic        accept;
   logic        last;
   logic [4:0]  bsel;

   assign bsel   = {beat_q[1:0], 3'b000};
   assign accept = req_valid & req_ready;
   assign last   = (beat_q == (beat_count(f3_q) - 3'd1));

   // Classify the incoming request as legal or not
   always_comb begin
      illegal = 1'b0;
      unique case (1'b1)
         (req_funct3 == F3_B || req_funct3 == F3_BU):
            illegal = 1'b0;
         (req_funct3 == F3_H || req_funct3 == F3_HU):
            illegal = CHECK_ALIGN & req_addr[0];
         (req_funct3 == F3_W):
            illegal = CHECK_ALIGN & (req_addr[1:0] != 2'b00);
         default:
            illegal = 1'b1;
      endcase
   end

   // Request latch, beat sequencing and load byte capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         up_q    <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         f3_q    <= '0;
         beat_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
      end else begin
         up_q <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  beat_q  <= '0;
                  data_q  <= '0;
                  err_q   <= illegal;
                  state   <= illegal ? S_RESP : S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (mem_ready) begin
                  if (!we_q)
                     data_q[bsel +: 8] <= mem_rdata;
                  beat_q <= beat_q + 3'd1;
                  if (last)
                     state <= S_RESP;
               end
            end
            S_RESP: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   load_extend u_ext (
      .data   (data_q),
      .funct3 (f3_q),
      .rdata  (ext)
   );

   // Handshake, memory and response outputs decoded from state
   always_comb begin
      req_ready = up_q & (state == S_IDLE);
      busy      = (state != S_IDLE);
      mem_en    = (state == S_ACCESS);
      mem_we    = mem_en & we_q;
      mem_addr  = mem_en ? (addr_q + {29'h0, beat_q}) : 32'h0;
      mem_wdata = mem_en ? wdata_q[bsel +: 8] : 8'h0;
      rsp_valid = (state == S_RESP);
      rsp_err   = rsp_valid & err_q;
      rsp_rdata = (rsp_valid & ~we_q & ~err_q) ? ext : 32'h0;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit.
// Two instances: alignment checking on (u0) and off (u1).
module tb_load_store_unit;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   typedef struct {
      bit          s;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] bytes;
      logic [31:0] exp;
      int          cyc;
      string       name;
   } ld_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        sel;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_ready;
   logic [7:0]  mem_rdata;

   logic        rr0, rv0, re0, bz0, me0, mw0;
   logic        rr1, rv1, re1, bz1, me1, mw1;
   logic [31:0] rd0, ma0, rd1, ma1;
   logic [7:0]  md0, md1;

   logic        req_ready_m, rsp_valid_m, rsp_err_m, busy_m;
   logic        mem_en_m, mem_we_m;
   logic [31:0] rsp_rdata_m, mem_addr_m;
   logic [7:0]  mem_wdata_m;

   assign req_ready_m = sel ? rr1 : rr0;
   assign rsp_valid_m = sel ? rv1 : rv0;
   assign rsp_err_m   = sel ? re1 : re0;
   assign busy_m      = sel ? bz1 : bz0;
   assign mem_en_m    = sel ? me1 : me0;
   assign mem_we_m    = sel ? mw1 : mw0;
   assign rsp_rdata_m = sel ? rd1 : rd0;
   assign mem_addr_m  = sel ? ma1 : ma0;
   assign mem_wdata_m = sel ? md1 : md0;

   logic [7:0] pre [0:255];
   logic [7:0] wr  [0:255];
   logic       wv  [0:255];
   logic [39:0] wlog [$];
   exp_t sb [$];

   int vectors = 0;
   int miscompares = 0;
   int ecount = 0;
   int acc_e = 0;
   int nbeat = 0;

   assign mem_rdata = wv[mem_addr_m[7:0]] ? wr[mem_addr_m[7:0]]
                                          : pre[mem_addr_m[7:0]];

   load_store_unit u0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid & ~sel), .req_ready(rr0),
      .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0), .busy(bz0),
      .mem_en(me0), .mem_we(mw0), .mem_addr(ma0), .mem_wdata(md0),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   load_store_unit #(.CHECK_ALIGN(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid & sel), .req_ready(rr1),
      .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1), .busy(bz1),
      .mem_en(me1), .mem_we(mw1), .mem_addr(ma1), .mem_wdata(md1),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   // Byte memory, beat counter and acceptance timestamp
   always @(posedge clk) begin
      ecount <= ecount + 1;
      if (req_valid && req_ready_m)
         acc_e <= ecount + 1;
      if (mem_en_m && mem_ready) begin
         nbeat <= nbeat + 1;
         if (mem_we_m) begin
            wr[mem_addr_m[7:0]] <= mem_wdata_m;
            wv[mem_addr_m[7:0]] <= 1'b1;
            wlog.push_back({mem_addr_m, mem_wdata_m});
         end
      end
   end

   task automatic issue(input bit s, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit eerr, input logic [31:0] erd,
                        input int ecyc);
      exp_t e;
      sel = s;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready_m) break;
      end
      req_we = we;
      req_funct3 = f3;
      req_addr = a;
      req_wdata = wd;
      req_valid = 1'b1;
      e.err = eerr;
      e.rdata = erd;
      e.cyc = ecyc;
      sb.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output bit got);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid_m) begin
            got = 1'b1;
            break;
         end
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL rsp_timeout: no rsp_valid in 40 cycles, want one");
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      vectors++;
      if ({rr0, rv0, re0, bz0, me0, mw0, rd0, ma0, md0} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got rr%b rv%b re%b bz%b me%b mw%b rd%h ma%h md%h, want all 0",
                  rr0, rv0, re0, bz0, me0, mw0, rd0, ma0, md0);
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (rr0 !== 1'b0) begin
         miscompares++;
         $display("FAIL ready_before_edge: got %b, want 0", rr0);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (rr0 !== 1'b1 || rr1 !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_after_edge: got %b/%b, want 1/1", rr0, rr1);
      end
   endtask

   task automatic test_loads;
      ld_t t [5];
      exp_t e;
      bit got;
      int cyc;
      t[0] = '{1'b0, 3'b000, 32'h28, 32'h80, 32'hFFFFFF80, 2, "LB"};
      t[1] = '{1'b0, 3'b100, 32'h28, 32'h80, 32'h00000080, 2, "LBU"};
      t[2] = '{1'b0, 3'b001, 32'h30, 32'h8000, 32'hFFFF8000, 3, "LH"};
      t[3] = '{1'b0, 3'b101, 32'h30, 32'h8000, 32'h00008000, 3, "LHU"};
      t[4] = '{1'b0, 3'b010, 32'h34, 32'h44332211, 32'h44332211, 5, "LW"};
      foreach (t[n]) begin
         for (int k = 0; k < 4; k++)
            pre[8'(t[n].a[7:0] + 8'(k))] = t[n].bytes[8*k +: 8];
         issue(t[n].s, 1'b0, t[n].f3, t[n].a, 32'h0, 1'b0, t[n].exp, t[n].cyc);
         wait_rsp(got);
         e = sb.pop_front();
         if (got) begin
            cyc = ecount - acc_e + 1;
            vectors++;
            if (rsp_rdata_m !== e.rdata) begin
               miscompares++;
               $display("FAIL %s rdata: got %h, want %h", t[n].name, rsp_rdata_m, e.rdata);
            end
            vectors++;
            if (rsp_err_m !== e.err || cyc != e.cyc) begin
               miscompares++;
               $display("FAIL %s err/cycle: got %b/%0d, want %b/%0d",
                        t[n].name, rsp_err_m, cyc, e.err, e.cyc);
            end
         end
      end
   endtask

   task automatic test_illegal;
      logic [2:0]  f3 [5];
      logic [31:0] a  [5];
      bit          we [5];
      exp_t e;
      bit got;
      int cyc;
      int nb;
      f3 = '{3'b001, 3'b011, 3'b110, 3'b111, 3'b010};
      a  = '{32'h29, 32'h28, 32'h28, 32'h28, 32'h2A};
      we = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int n = 0; n < 5; n++) begin
         nb = nbeat;
         issue(1'b0, we[n], f3[n], a[n], 32'hCAFEF00D, 1'b1, 32'h0, 1);
         wait_rsp(got);
         e = sb.pop_front();
         if (got) begin
            cyc = ecount - acc_e + 1;
            vectors++;
            if (rsp_err_m !== e.err || rsp_rdata_m !== e.rdata || cyc != e.cyc) begin
               miscompares++;
               $display("FAIL illegal%0d: got err%b rd%h cyc%0d, want err1 rd0 cyc1",
                        n, rsp_err_m, rsp_rdata_m, cyc);
            end
         end
         vectors++;
         if (nbeat != nb) begin
            miscompares++;
            $display("FAIL illegal%0d_beats: got %0d beats, want 0", n, nbeat - nb);
         end
      end
   endtask

   task automatic test_unaligned;
      ld_t t [3];
      exp_t e;
      bit got;
      int cyc;
      t[0] = '{1'b1, 3'b001, 32'h29, 32'h1234, 32'h00001234, 3, "LH_mis"};
      t[1] = '{1'b1, 3'b010, 32'hFFFFFFFF, 32'hD4C3B2A1, 32'hD4C3B2A1, 5, "LW_wrap"};
      t[2] = '{1'b1, 3'b001, 32'h43, 32'hFFFE, 32'hFFFFFFFE, 3, "LH_mis_neg"};
      foreach (t[n]) begin
         for (int k = 0; k < 4; k++)
            pre[8'(t[n].a[7:0] + 8'(k))] = t[n].bytes[8*k +: 8];
         issue(t[n].s, 1'b0, t[n].f3, t[n].a, 32'h0, 1'b0, t[n].exp, t[n].cyc);
         wait_rsp(got);
         e = sb.pop_front();
         if (got) begin
            cyc = ecount - acc_e + 1;
            vectors++;
            if (rsp_rdata_m !== e.rdata || rsp_err_m !== e.err || cyc != e.cyc) begin
               miscompares++;
               $display("FAIL %s: got rd%h err%b cyc%0d, want rd%h err%b cyc%0d",
                        t[n].name, rsp_rdata_m, rsp_err_m, cyc, e.rdata, e.err, e.cyc);
            end
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_back_to_back;
      exp_t e;
      bit got;
      bit seen;
      int cyc;
      int nw;
      pre[8'h28] = 8'h11;
      pre[8'h29] = 8'h22;
      pre[8'h2A] = 8'h33;
      pre[8'h2B] = 8'h44;
      nw = wlog.size();
      issue(1'b0, 1'b0, 3'b010, 32'h28, 32'h0, 1'b0, 32'h44332211, 8);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_en_m && mem_addr_m == 32'h2A) begin
            seen = 1'b1;
            break;
         end
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL stall_reach: beat at 0x2A not seen, want it by cycle 3");
      end
      mem_ready = 1'b0;
      req_we = 1'b1;
      req_funct3 = 3'b010;
      req_addr = 32'h40;
      req_wdata = 32'h55555555;
      req_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (mem_en_m !== 1'b1 || mem_addr_m !== 32'h2A || req_ready_m !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold%0d: got en%b addr%h rdy%b, want en1 addr0000002a rdy0",
                     k, mem_en_m, mem_addr_m, req_ready_m);
         end
         @(negedge clk);
      end
      mem_ready = 1'b1;
      req_valid = 1'b0;
      wait_rsp(got);
      e = sb.pop_front();
      if (got) begin
         cyc = ecount - acc_e + 1;
         vectors++;
         if (rsp_rdata_m !== e.rdata || rsp_err_m !== e.err || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL LW_stall: got rd%h err%b cyc%0d, want rd%h err%b cyc%0d",
                     rsp_rdata_m, rsp_err_m, cyc, e.rdata, e.err, e.cyc);
         end
      end
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid_m || mem_en_m) seen = 1'b1;
      end
      vectors++;
      if (seen || wv[8'h40] !== 1'b0 || wlog.size() != nw) begin
         miscompares++;
         $display("FAIL busy_ignore: got extra activity %b write %b, want none",
                  seen, wv[8'h40]);
      end
   endtask

   task automatic test_reset_mid_access;
      bit seen;
      sel = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready_m) break;
      end
      req_we = 1'b1;
      req_funct3 = 3'b010;
      req_addr = 32'h50;
      req_wdata = 32'h11223344;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (mem_en_m !== 1'b1 || mem_addr_m !== 32'h51) begin
         miscompares++;
         $display("FAIL rst_mid_beat1: got en%b addr%h, want en1 addr00000051",
                  mem_en_m, mem_addr_m);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (mem_en_m !== 1'b0 || busy_m !== 1'b0 || req_ready_m !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_abort: got en%b busy%b rdy%b, want 0 0 0",
                  mem_en_m, busy_m, req_ready_m);
      end
      seen = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (rsp_valid_m) seen = 1'b1;
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (req_ready_m !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_release: got rdy%b, want 0", req_ready_m);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (req_ready_m !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_ready: got rdy%b, want 1", req_ready_m);
      end
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid_m) seen = 1'b1;
      end
      vectors++;
      if (seen || wr[8'h50] !== 8'h44 || wv[8'h51] !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_mem: got rsp%b b50=%h w51=%b, want 0 44 0",
                  seen, wr[8'h50], wv[8'h51]);
      end
   endtask

   task automatic test_store_word;
      exp_t e;
      bit got;
      int cyc;
      int nw;
      logic [39:0] want [4];
      want = '{{32'h28, 8'hEF}, {32'h29, 8'hBE}, {32'h2A, 8'hAD}, {32'h2B, 8'hDE}};
      nw = wlog.size();
      issue(1'b0, 1'b1, 3'b010, 32'h28, 32'hDEADBEEF, 1'b0, 32'h0, 5);
      wait_rsp(got);
      e = sb.pop_front();
      if (got) begin
         cyc = ecount - acc_e + 1;
         vectors++;
         if (rsp_rdata_m !== e.rdata || rsp_err_m !== e.err || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL SW_rsp: got rd%h err%b cyc%0d, want rd0 err0 cyc5",
                     rsp_rdata_m, rsp_err_m, cyc);
         end
      end
      @(negedge clk);
      vectors++;
      if (rsp_valid_m !== 1'b0) begin
         miscompares++;
         $display("FAIL SW_pulse: rsp_valid got %b one cycle later, want 0", rsp_valid_m);
      end
      vectors++;
      if (wlog.size() - nw != 4) begin
         miscompares++;
         $display("FAIL SW_beats: got %0d writes, want 4", wlog.size() - nw);
      end else begin
         for (int k = 0; k < 4; k++) begin
            vectors++;
            if (wlog[nw + k] !== want[k]) begin
               miscompares++;
               $display("FAIL SW_byte%0d: got %h, want %h", k, wlog[nw + k], want[k]);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      sel = 1'b0;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_funct3 = 3'b000;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      mem_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         pre[i] = 8'h00;
         wr[i] = 8'h00;
         wv[i] = 1'b0;
      end
      test_reset();
      test_loads();
      test_illegal();
      test_unaligned();
      test_back_to_back();
      test_reset_mid_access();
      test_store_word();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
